// File: rtl/ripple_down_counter.sv
// Loadable WIDTH-bit down-counter/timer: IDLE/RUN/DONE control, one-shot or auto-reload, tc pulse.
// Define RIPPLE_DOWN_PRESCALE_EN to slow the count to one tick per PRESCALE clocks.
module ripple_down_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rl_val_q, rl_val_d;
  logic             rl_q, rl_d;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;
  logic             accept;
  logic             tick;

  assign accept = (state_q != RUN) && start && !stop;

`ifdef RIPPLE_DOWN_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] ps_q, ps_d;

  assign tick = (ps_q == PW'(PRESCALE - 1));

  // Prescaler only advances in RUN; a fresh start or an abort restarts the window.
  always_comb begin
    ps_d = ps_q;
    if (state_q == RUN) ps_d = tick ? '0 : ps_q + 1'b1;
    if (accept || stop) ps_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ps_q <= '0;
    else        ps_q <= ps_d;
  end
`else
  // Every cycle is a tick; PRESCALE is referenced only to keep it a live parameter.
  assign tick = (PRESCALE != 0) | 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    rl_val_d = rl_val_q;
    rl_d     = rl_q;
    tc_d     = 1'b0;
    case (state_q)
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tick) begin
          if (q_q == '0) begin
            q_d = rl_val_q;
          end else begin
            q_d = q_q - 1'b1;
            if (q_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (!rl_q) state_d = DONE;
            end
          end
        end
      end
      default: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          rl_val_d = load_val;
          rl_d     = auto_reload;
          q_d      = load_val;
          if (load_val == '0) begin
            state_d = DONE;
            tc_d    = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      rl_val_q <= '0;
      rl_q     <= 1'b0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      rl_val_q <= rl_val_d;
      rl_q     <= rl_d;
      tc_q     <= tc_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_ripple_down_counter.sv
// Randomized + directed bench for ripple_down_counter; expectations come from a countdown model
// queued per cycle and checked by an independent monitor.
module tb_ripple_down_counter;
  localparam int W  = 4;
  localparam int PS = `ifdef RIPPLE_DOWN_PRESCALE_EN 4 `else 1 `endif;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0, stop = 1'b0, auto_reload = 1'b0;
  logic [W-1:0] q;
  logic         busy, done, tc;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         tc;
  } obs_t;

  obs_t exp_q[$];

  // Model: a timer that is either counting, finished, or parked.
  int m_q = 0, m_val = 0, m_phase = 0;
  bit m_busy = 0, m_done = 0, m_tc = 0, m_ar = 0;

  ripple_down_counter #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .load_val(load_val), .start(start), .stop(stop),
    .auto_reload(auto_reload), .q(q), .busy(busy), .done(done), .tc(tc)
  );

  always #5 clk = ~clk;

  function automatic obs_t m_obs();
    obs_t o;
    o.q = W'(m_q); o.busy = m_busy; o.done = m_done; o.tc = m_tc;
    return o;
  endfunction

  task automatic step_model(input bit s, input bit p, input int lv, input bit ar);
    bit t;
    m_tc = 0;
    if (!m_busy) begin
      if (p) begin
        m_done = 0;
      end else if (s) begin
        m_val = lv; m_ar = ar; m_q = lv; m_phase = 0;
        if (lv == 0) begin m_done = 1; m_tc = 1; end
        else begin m_busy = 1; m_done = 0; end
      end
    end else if (p) begin
      m_busy = 0; m_phase = 0;
    end else begin
      t = (m_phase == PS - 1);
      m_phase = t ? 0 : m_phase + 1;
      if (t) begin
        if (m_q == 0) m_q = m_val;
        else begin
          m_q = m_q - 1;
          if (m_q == 0) begin
            m_tc = 1;
            if (!m_ar) begin m_busy = 0; m_done = 1; end
          end
        end
      end
    end
  endtask

  task automatic drive(input bit s, input bit p, input int lv, input bit ar);
    @(negedge clk);
    reset = 1'b1; start = s; stop = p; load_val = W'(lv); auto_reload = ar;
    step_model(s, p, lv, ar);
    exp_q.push_back(m_obs());
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  task automatic chk_now(input string name, input obs_t e);
    obs_t a;
    a.q = q; a.busy = busy; a.done = done; a.tc = tc;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got q=%0d busy=%0b done=%0b tc=%0b need q=%0d busy=%0b done=%0b tc=%0b",
               name, a.q, a.busy, a.done, a.tc, e.q, e.busy, e.done, e.tc);
    end
  endtask

  initial begin
    obs_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_now("cycle", e);
      end
    end
  end

  initial begin
    obs_t zero;
    int guard;
    zero = '0;
    #3 chk_now("reset_state", zero);

    drive(1, 0, 3, 0); idle(5 * PS);                    // one-shot
    drive(1, 0, 2, 1); idle(7 * PS);                    // auto-reload
    drive(1, 0, 9, 0); idle(2);                         // start in RUN ignored
    drive(0, 1, 0, 0); idle(2);
    drive(1, 0, 0, 0); idle(2);                         // zero load
    drive(1, 0, 15, 0); idle(16 * PS + 1);              // full range
    drive(1, 0, 9, 0);                                  // stop at q=6
    guard = 0;
    while (m_q != 6 && guard < 200) begin idle(1); guard++; end
    drive(0, 1, 0, 0); idle(3);
    drive(1, 1, 5, 0); idle(2);                         // start+stop in IDLE
    drive(1, 0, 0, 0); drive(1, 1, 4, 0); idle(1);      // start+stop in DONE

    // Asynchronous reset while counting at q=5.
    drive(1, 0, 7, 0);
    guard = 0;
    while (m_q != 5 && guard < 200) begin idle(1); guard++; end
    @(negedge clk); #2 reset = 1'b0; #1;
    chk_now("async_reset", zero);
    m_q = 0; m_val = 0; m_phase = 0; m_busy = 0; m_done = 0; m_tc = 0; m_ar = 0;
    exp_q.push_back(m_obs());

    repeat (400) begin
      if ($urandom_range(0, 3) == 0)
        drive($urandom_range(0, 1), $urandom_range(0, 15) == 0, $urandom_range(0, 15), $urandom_range(0, 1));
      else
        drive(0, $urandom_range(0, 31) == 0, $urandom_range(0, 15), $urandom_range(0, 1));
    end
    idle(2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d need 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running need finished");
    $fatal(1);
  end
endmodule
